// File: rtl/prog_loader_if.sv
// ---------------------------------------------------------------------------
// prog_loader_if
// Byte-stream handshake between an external byte source (UART RX or a test
// harness) and the boot loader.
//
// Signals
//   in_valid  source -> loader  in_byte holds a valid byte
//   in_byte   source -> loader  stream byte
//   in_ready  loader -> source  loader accepts a byte this cycle
//
// Modports
//   master  the byte source (drives in_valid/in_byte)
//   slave   the loader (drives in_ready)
// ---------------------------------------------------------------------------
interface prog_loader_if;
   logic       in_valid;
   logic [7:0] in_byte;
   logic       in_ready;

   modport master (
      output in_valid,
      output in_byte,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_byte,
      output in_ready
   );
endinterface

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
// Byte-stream boot loader. Receives LEN_HI, LEN_LO (N, big-endian), then N
// {HI, LO} instruction words, then a checksum byte. Each word is written to
// program memory as it completes. The CPU is held in halt until the whole
// image has arrived and the XOR of every byte (length and checksum included)
// is zero.
//
// Parameters
//   ADDR_W     program memory byte-address width
//   BASE_ADDR  byte address of the first instruction word
//   MAX_WORDS  largest accepted word count; a larger count is an error
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous reset, active low
//   start          one-cycle pulse, aborts any load and restarts at LEN_HI
//   stream         byte-stream handshake (slave side)
//   pm_write_en    program memory write strobe, one cycle per word
//   pm_address     byte address of the word being written
//   pm_write_data  instruction word {HI, LO}
//   cpu_hold       holds the core halted; low only once the image is verified
//   done           image loaded and verified
//   error          checksum or length failure
//   words_loaded   words written in the current load
// ---------------------------------------------------------------------------
module prog_loader #(
   parameter int                ADDR_W    = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                MAX_WORDS = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   prog_loader_if.slave      stream,
   output logic              pm_write_en,
   output logic [ADDR_W-1:0] pm_address,
   output logic [15:0]       pm_write_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [15:0]       words_loaded
);

   localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

   typedef enum logic [2:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_DATA_HI,
      S_DATA_LO,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   state_t            state;
   logic [7:0]        xor_acc;
   logic [7:0]        len_hi;
   logic [7:0]        hi_byte;
   logic [15:0]       word_total;

   logic              ready;
   logic              accept;
   logic [7:0]        xor_next;
   logic [15:0]       len_value;
   logic [ADDR_W-1:0] word_address;

   // The loader only listens while a stream is in progress; a start pulse
   // masks ready so a byte arriving together with start is never consumed.
   assign ready           = (state inside {S_LEN_HI, S_LEN_LO, S_DATA_HI,
                                           S_DATA_LO, S_CHECK}) && !start;
   assign stream.in_ready = ready;
   assign accept          = stream.in_valid && ready;

   assign xor_next  = xor_acc ^ stream.in_byte;
   assign len_value = {len_hi, stream.in_byte};

   // Address of the word about to be written; words_loaded is still the
   // 0-based index of that word. Wraps silently at 2^ADDR_W.
   assign word_address = BASE_ADDR + ADDR_W'({words_loaded, 1'b0});

   // Stream parser, word writer and status outputs. All outputs are
   // registered; pm_write_en is cleared every cycle so it pulses once per
   // completed word. start takes priority over any byte acceptance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_LEN_HI;
         xor_acc       <= 8'h00;
         len_hi        <= 8'h00;
         hi_byte       <= 8'h00;
         word_total    <= 16'h0000;
         pm_write_en   <= 1'b0;
         pm_address    <= BASE_ADDR;
         pm_write_data <= 16'h0000;
         cpu_hold      <= 1'b1;
         done          <= 1'b0;
         error         <= 1'b0;
         words_loaded  <= 16'h0000;
      end else begin
         pm_write_en <= 1'b0;
         if (start) begin
            state        <= S_LEN_HI;
            xor_acc      <= 8'h00;
            words_loaded <= 16'h0000;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_hold     <= 1'b1;
         end else if (accept) begin
            xor_acc <= xor_next;
            case (state)
               S_LEN_HI: begin
                  len_hi <= stream.in_byte;
                  state  <= S_LEN_LO;
               end
               S_LEN_LO: begin
                  word_total <= len_value;
                  if (len_value == 16'h0000) begin
                     state <= S_CHECK;
                  end else if (len_value > MAX_N) begin
                     state    <= S_ERROR;
                     error    <= 1'b1;
                     cpu_hold <= 1'b1;
                  end else begin
                     state <= S_DATA_HI;
                  end
               end
               S_DATA_HI: begin
                  hi_byte <= stream.in_byte;
                  state   <= S_DATA_LO;
               end
               S_DATA_LO: begin
                  pm_write_en   <= 1'b1;
                  pm_address    <= word_address;
                  pm_write_data <= {hi_byte, stream.in_byte};
                  words_loaded  <= words_loaded + 16'd1;
                  if (words_loaded + 16'd1 == word_total) begin
                     state <= S_CHECK;
                  end else begin
                     state <= S_DATA_HI;
                  end
               end
               S_CHECK: begin
                  if (xor_next == 8'h00) begin
                     state    <= S_DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state    <= S_ERROR;
                     error    <= 1'b1;
                     cpu_hold <= 1'b1;
                  end
               end
               default: begin
                  state <= state;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
// Self-checking bench for prog_loader. A behavioural model parses the byte
// stream held in stream_q (length, words, checksum) and produces the list of
// expected program-memory writes and the final done/error status. A monitor
// records every pm_write_en pulse; each test task compares the recorded
// writes and status against the model.
// ---------------------------------------------------------------------------
module tb_prog_loader;

   localparam int          ADDR_W = 16;
   localparam logic [15:0] BASE   = 16'h0000;
   localparam int          MAXW   = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        pm_write_en;
   logic [15:0] pm_address;
   logic [15:0] pm_write_data;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [15:0] words_loaded;

   prog_loader_if bus ();

   prog_loader #(
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (BASE),
      .MAX_WORDS (MAXW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .stream        (bus),
      .pm_write_en   (pm_write_en),
      .pm_address    (pm_address),
      .pm_write_data (pm_write_data),
      .cpu_hold      (cpu_hold),
      .done          (done),
      .error         (error),
      .words_loaded  (words_loaded)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   logic [7:0]  stream_q[$];
   logic [15:0] obs_addr[$];
   logic [15:0] obs_data[$];
   logic [15:0] obs_wl[$];
   logic [15:0] exp_addr[$];
   logic [15:0] exp_data[$];
   bit          exp_done;
   bit          exp_error;
   int          exp_consumed;
   int          n_vec = 0;
   int          n_err = 0;

   // Records every program-memory write together with the word count seen
   // in the same cycle.
   always @(negedge clk) begin
      if (pm_write_en) begin
         obs_addr.push_back(pm_address);
         obs_data.push_back(pm_write_data);
         obs_wl.push_back(words_loaded);
      end
   end

   // Reference model: interprets stream_q by the stream format rules.
   task automatic build_model();
      int         n;
      logic [7:0] x;
      exp_addr.delete();
      exp_data.delete();
      exp_done  = 1'b0;
      exp_error = 1'b0;
      n = {stream_q[0], stream_q[1]};
      if (n > MAXW) begin
         exp_error    = 1'b1;
         exp_consumed = 2;
      end else begin
         for (int k = 0; k < n; k++) begin
            exp_addr.push_back(16'(BASE + 2 * k));
            exp_data.push_back({stream_q[2 + 2 * k], stream_q[3 + 2 * k]});
         end
         x = 8'h00;
         for (int i = 0; i < 3 + 2 * n; i++) x ^= stream_q[i];
         if (x == 8'h00) exp_done = 1'b1;
         else            exp_error = 1'b1;
         exp_consumed = 3 + 2 * n;
      end
   endtask

   // Builds a random well-formed stream of n words; a bad checksum is made
   // by flipping at least one bit of the correct one.
   task automatic make_stream(input int n, input bit good_chk);
      logic [7:0] x;
      stream_q.delete();
      stream_q.push_back(8'(n >> 8));
      stream_q.push_back(8'(n));
      for (int k = 0; k < 2 * n; k++) stream_q.push_back(8'($urandom));
      x = 8'h00;
      foreach (stream_q[i]) x ^= stream_q[i];
      if (!good_chk) x ^= 8'($urandom_range(1, 255));
      stream_q.push_back(x);
   endtask

   task automatic set_reference_stream(input logic [7:0] chk);
      stream_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, chk};
   endtask

   // Pulses start for one cycle and forgets writes from earlier loads.
   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      obs_addr.delete();
      obs_data.delete();
      obs_wl.delete();
   endtask

   // Offers stream_q[first .. first+count-1] with random in_valid gaps.
   // Stops early once a byte goes unaccepted for 60 cycles.
   task automatic applyStimulus(input int first, input int count,
                                input int gap_pct, output int accepted);
      bit r;
      bit v;
      accepted = 0;
      for (int i = first; i < first + count; i++) begin
         int waited = 0;
         bit took = 1'b0;
         while (!took && waited < 60) begin
            @(negedge clk);
            if ($urandom_range(99) < gap_pct) begin
               bus.in_valid = 1'b0;
               bus.in_byte  = 8'($urandom);
            end else begin
               bus.in_valid = 1'b1;
               bus.in_byte  = stream_q[i];
            end
            #1;
            r = bus.in_ready;
            v = bus.in_valid;
            @(posedge clk);
            if (v && r) took = 1'b1;
            waited++;
         end
         if (!took) break;
         accepted++;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      n_vec++;
      if ({cpu_hold, done, error, pm_write_en, bus.in_ready} !== 5'b10001) begin
         n_err++;
         $display("[TB] FAIL reset_flags: got %b expected %b",
                  {cpu_hold, done, error, pm_write_en, bus.in_ready}, 5'b10001);
      end
      n_vec++;
      if ({pm_address, pm_write_data, words_loaded} !== {BASE, 16'h0, 16'h0}) begin
         n_err++;
         $display("[TB] FAIL reset_values: got %h expected %h",
                  {pm_address, pm_write_data, words_loaded}, {BASE, 16'h0, 16'h0});
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_basic();
      int acc;
      pulse_start();
      set_reference_stream(8'h42);
      build_model();
      applyStimulus(0, stream_q.size(), 0, acc);
      n_vec++;
      if (obs_addr.size() !== exp_addr.size()) begin
         n_err++;
         $display("[TB] FAIL basic_count: got %0d expected %0d", obs_addr.size(), exp_addr.size());
      end
      foreach (exp_addr[k]) if (k < obs_addr.size()) begin
         n_vec++;
         if ({obs_addr[k], obs_data[k], obs_wl[k]} !== {exp_addr[k], exp_data[k], 16'(k + 1)}) begin
            n_err++;
            $display("[TB] FAIL basic_write%0d: got %h expected %h", k,
                     {obs_addr[k], obs_data[k], obs_wl[k]}, {exp_addr[k], exp_data[k], 16'(k + 1)});
         end
      end
      n_vec++;
      if ({done, error, cpu_hold, bus.in_ready, words_loaded} !== {4'b1000, 16'd2}) begin
         n_err++;
         $display("[TB] FAIL basic_status: got %h expected %h",
                  {done, error, cpu_hold, bus.in_ready, words_loaded}, {4'b1000, 16'd2});
      end
   endtask

   task automatic test_bad_checksum();
      int acc;
      pulse_start();
      set_reference_stream(8'h43);
      build_model();
      stream_q.push_back(8'h00);
      stream_q.push_back(8'h01);
      applyStimulus(0, stream_q.size(), 20, acc);
      n_vec++;
      if (acc !== exp_consumed) begin
         n_err++;
         $display("[TB] FAIL badchk_accepted: got %0d expected %0d", acc, exp_consumed);
      end
      n_vec++;
      if (obs_data.size() !== 2 || obs_data[0] !== 16'h1234 || obs_data[1] !== 16'hABCD) begin
         n_err++;
         $display("[TB] FAIL badchk_writes: got %0d writes expected 2 (1234, ABCD)", obs_data.size());
      end
      n_vec++;
      if ({done, error, cpu_hold, bus.in_ready} !== {1'b0, exp_error, 1'b1, 1'b0}) begin
         n_err++;
         $display("[TB] FAIL badchk_status: got %b expected %b",
                  {done, error, cpu_hold, bus.in_ready}, {1'b0, exp_error, 1'b1, 1'b0});
      end
   endtask

   task automatic test_empty();
      int acc;
      pulse_start();
      stream_q = '{8'h00, 8'h00, 8'h00};
      build_model();
      applyStimulus(0, 3, 0, acc);
      n_vec++;
      if (obs_addr.size() !== 0) begin
         n_err++;
         $display("[TB] FAIL empty_writes: got %0d expected 0", obs_addr.size());
      end
      n_vec++;
      if ({done, error, cpu_hold, words_loaded} !== {exp_done, exp_error, !exp_done, 16'd0}) begin
         n_err++;
         $display("[TB] FAIL empty_status: got %h expected %h",
                  {done, error, cpu_hold, words_loaded}, {exp_done, exp_error, !exp_done, 16'd0});
      end
   endtask

   task automatic test_too_long();
      int acc;
      pulse_start();
      make_stream(MAXW + 1, 1'b1);
      build_model();
      applyStimulus(0, 2, 0, acc);
      n_vec++;
      if ({error, cpu_hold, done, bus.in_ready} !== {exp_error, 3'b100}) begin
         n_err++;
         $display("[TB] FAIL toolong_status: got %b expected %b",
                  {error, cpu_hold, done, bus.in_ready}, {exp_error, 3'b100});
      end
      applyStimulus(2, 4, 0, acc);
      n_vec++;
      if (acc !== 0 || obs_addr.size() !== 0) begin
         n_err++;
         $display("[TB] FAIL toolong_ignored: got %0d accepted %0d writes expected 0 0",
                  acc, obs_addr.size());
      end
   endtask

   task automatic test_start_collision();
      int acc;
      bit r;
      pulse_start();
      set_reference_stream(8'h42);
      build_model();
      applyStimulus(0, 3, 0, acc);
      @(negedge clk);
      start        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_byte  = 8'h34;
      #1;
      r = bus.in_ready;
      n_vec++;
      if (r !== 1'b0) begin
         n_err++;
         $display("[TB] FAIL collide_ready: got %b expected 0", r);
      end
      @(negedge clk);
      start        = 1'b0;
      bus.in_valid = 1'b0;
      applyStimulus(0, stream_q.size(), 35, acc);
      n_vec++;
      if (obs_addr.size() !== exp_addr.size()) begin
         n_err++;
         $display("[TB] FAIL collide_count: got %0d expected %0d", obs_addr.size(), exp_addr.size());
      end
      foreach (exp_addr[k]) if (k < obs_addr.size()) begin
         n_vec++;
         if ({obs_addr[k], obs_data[k]} !== {exp_addr[k], exp_data[k]}) begin
            n_err++;
            $display("[TB] FAIL collide_write%0d: got %h expected %h", k,
                     {obs_addr[k], obs_data[k]}, {exp_addr[k], exp_data[k]});
         end
      end
      n_vec++;
      if ({done, cpu_hold} !== 2'b10) begin
         n_err++;
         $display("[TB] FAIL collide_status: got %b expected 10", {done, cpu_hold});
      end
   endtask

   task automatic test_random(input int n, input bit good, input int gap_pct);
      int acc;
      pulse_start();
      make_stream(n, good);
      build_model();
      applyStimulus(0, stream_q.size(), gap_pct, acc);
      n_vec++;
      if (acc !== exp_consumed || obs_addr.size() !== exp_addr.size()) begin
         n_err++;
         $display("[TB] FAIL random_n%0d_count: got %0d bytes %0d writes expected %0d %0d",
                  n, acc, obs_addr.size(), exp_consumed, exp_addr.size());
      end
      foreach (exp_addr[k]) if (k < obs_addr.size()) begin
         if ({obs_addr[k], obs_data[k], obs_wl[k]} !== {exp_addr[k], exp_data[k], 16'(k + 1)}) begin
            n_err++;
            $display("[TB] FAIL random_n%0d_write%0d: got %h expected %h", n, k,
                     {obs_addr[k], obs_data[k], obs_wl[k]}, {exp_addr[k], exp_data[k], 16'(k + 1)});
         end
      end
      n_vec++;
      if ({done, error, cpu_hold, words_loaded} !== {exp_done, exp_error, !exp_done, 16'(n)}) begin
         n_err++;
         $display("[TB] FAIL random_n%0d_status: got %h expected %h", n,
                  {done, error, cpu_hold, words_loaded}, {exp_done, exp_error, !exp_done, 16'(n)});
      end
   endtask

   task automatic test_reset_mid_word();
      int acc;
      pulse_start();
      set_reference_stream(8'h42);
      build_model();
      applyStimulus(0, 5, 0, acc);
      n_vec++;
      if (obs_addr.size() !== 1) begin
         n_err++;
         $display("[TB] FAIL midword_prewrites: got %0d expected 1", obs_addr.size());
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_vec++;
      if ({cpu_hold, done, error, pm_write_en, pm_address, pm_write_data, words_loaded} !==
          {4'b1000, BASE, 16'h0, 16'h0}) begin
         n_err++;
         $display("[TB] FAIL midword_reset: got %h expected %h",
                  {cpu_hold, done, error, pm_write_en, pm_address, pm_write_data, words_loaded},
                  {4'b1000, BASE, 16'h0, 16'h0});
      end
      @(negedge clk);
      rst = 1'b1;
      obs_addr.delete();
      obs_data.delete();
      obs_wl.delete();
      applyStimulus(0, stream_q.size(), 25, acc);
      n_vec++;
      if (obs_addr.size() !== 2) begin
         n_err++;
         $display("[TB] FAIL midword_count: got %0d expected 2", obs_addr.size());
      end
      foreach (exp_addr[k]) if (k < obs_addr.size()) begin
         n_vec++;
         if ({obs_addr[k], obs_data[k]} !== {exp_addr[k], exp_data[k]}) begin
            n_err++;
            $display("[TB] FAIL midword_write%0d: got %h expected %h", k,
                     {obs_addr[k], obs_data[k]}, {exp_addr[k], exp_data[k]});
         end
      end
      n_vec++;
      if ({done, cpu_hold} !== 2'b10) begin
         n_err++;
         $display("[TB] FAIL midword_status: got %b expected 10", {done, cpu_hold});
      end
   endtask

   // Test sequence.
   initial begin
      bus.in_valid = 1'b0;
      bus.in_byte  = 8'h00;
      test_reset();
      test_basic();
      test_bad_checksum();
      test_empty();
      test_too_long();
      test_start_collision();
      for (int t = 0; t < 6; t++) begin
         test_random($urandom_range(1, 24), ($urandom_range(0, 3) != 0), 30);
      end
      test_random(MAXW, 1'b1, 10);
      test_reset_mid_word();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
